// File: rtl/hand_score_accumulator.sv
// Running hand scorer: accepts one card per handshake, keeps total mod MOD and card count.
// Optional natural detection (two cards scoring 8 or 9) is enabled by HAND_NATURAL_EN.
module hand_score_accumulator #(
    parameter int MAX_CARDS  = 3,
    parameter int MOD        = 10,
    parameter int FACE_LIMIT = 9,
    localparam int CW        = $clog2(MAX_CARDS + 1)
) (
    input  logic          slow_clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          card_valid,
    input  logic [3:0]    card,
    output logic          card_ready,
    output logic [3:0]    total,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          natural
);

    // Handshake: a card transfers on a rising edge where card_valid && card_ready
    // and neither clear nor reset is asserted; card_ready depends on registered state only.

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    total_q, total_n;
    logic [CW-1:0] count_q, count_n;
    logic [3:0]    card_value;
    logic [4:0]    sum;
    logic          accept;
    logic          natural_lock;
    logic          natural_set;

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            total_q <= 4'd0;
            count_q <= '0;
        end else begin
            total_q <= total_n;
            count_q <= count_n;
        end
    end

    always_comb begin
        state       = PARTIAL;
        card_value  = 4'd0;
        sum         = 5'd0;
        accept      = 1'b0;
        total_n     = total_q;
        count_n     = count_q;
        natural_set = 1'b0;

        // The count register is the FSM state; the enum names its regions.
        if (count_q == '0)
            state = EMPTY;
        else if (count_q == CW'(MAX_CARDS))
            state = FULL;

        card_value = (card <= 4'(FACE_LIMIT)) ? card : 4'd0;
        sum        = {1'b0, total_q} + {1'b0, card_value};
        accept     = card_valid && card_ready && !clear && !reset;

        if (reset || clear) begin
            total_n = 4'd0;
            count_n = '0;
        end else if (accept) begin
            // sum < 2*MOD for every legal MOD, so one subtract replaces a modulo.
            total_n = (sum >= 5'(MOD)) ? 4'(sum - 5'(MOD)) : sum[3:0];
            count_n = count_q + CW'(1);
            natural_set = (MAX_CARDS >= 2) && (count_q == CW'(1)) &&
                          ((total_n == 4'd8) || (total_n == 4'd9));
        end
    end

`ifdef HAND_NATURAL_EN
    logic natural_q;

    always_ff @(posedge slow_clock) begin
        if (reset || clear)
            natural_q <= 1'b0;
        else if (natural_set)
            natural_q <= 1'b1;
    end

    assign natural      = natural_q;
    assign natural_lock = natural_q;
`else
    logic unused_natural_set;

    assign unused_natural_set = natural_set;
    assign natural            = 1'b0;
    assign natural_lock       = 1'b0;
`endif

    assign total      = total_q;
    assign count      = count_q;
    assign full       = (state == FULL);
    assign card_ready = !full && !natural_lock;

endmodule

// File: tb/tb_hand_score_accumulator.sv
// Directed bench for hand_score_accumulator: default instance plus a MOD=12, MAX_CARDS=5 instance.
// Expectations for the natural case follow HAND_NATURAL_EN as seen by this compile.
module tb_hand_score_accumulator;

    logic       slow_clock;
    logic       reset;
    logic       clear;
    logic       card_valid;
    logic [3:0] card;
    logic       card_ready;
    logic [3:0] total;
    logic [1:0] count;
    logic       full;
    logic       natural;

    logic       clear1;
    logic       card_valid1;
    logic [3:0] card1;
    logic       card_ready1;
    logic [3:0] total1;
    logic [2:0] count1;
    logic       full1;
    logic       natural1;

    int checks = 0;
    int errors = 0;

    hand_score_accumulator u_dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .clear      (clear),
        .card_valid (card_valid),
        .card       (card),
        .card_ready (card_ready),
        .total      (total),
        .count      (count),
        .full       (full),
        .natural    (natural)
    );

    hand_score_accumulator #(.MAX_CARDS(5), .MOD(12), .FACE_LIMIT(9)) u_sweep (
        .slow_clock (slow_clock),
        .reset      (reset),
        .clear      (clear1),
        .card_valid (card_valid1),
        .card       (card1),
        .card_ready (card_ready1),
        .total      (total1),
        .count      (count1),
        .full       (full1),
        .natural    (natural1)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic deal(input logic [3:0] c);
        card_valid = 1'b1;
        card       = c;
        tick();
        card_valid = 1'b0;
    endtask

    task automatic deal1(input logic [3:0] c);
        card_valid1 = 1'b1;
        card1       = c;
        tick();
        card_valid1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; card_valid = 1'b1; card = 4'd5;
        clear1 = 1'b0; card_valid1 = 1'b1; card1 = 4'd5;
        tick();
        tick();
        reset = 1'b0; card_valid = 1'b0; card_valid1 = 1'b0;
        chk("rst_total", 8'(total), 8'd0);
        chk("rst_count", 8'(count), 8'd0);
        chk("rst_full", 8'(full), 8'd0);
        chk("rst_ready", 8'(card_ready), 8'd1);
        chk("rst_natural", 8'(natural), 8'd0);
        chk("rst_total1", 8'(total1), 8'd0);
        chk("rst_count1", 8'(count1), 8'd0);

        // 9, 8, 7 fill the default hand; a fourth card is ignored.
        deal(4'd9);
        chk("seq_total_1", 8'(total), 8'd9);
        chk("seq_count_1", 8'(count), 8'd1);
        deal(4'd8);
        chk("seq_total_2", 8'(total), 8'd7);
        chk("seq_count_2", 8'(count), 8'd2);
        chk("seq_full_2", 8'(full), 8'd0);
        deal(4'd7);
        chk("seq_total_3", 8'(total), 8'd4);
        chk("seq_count_3", 8'(count), 8'd3);
        chk("seq_full_3", 8'(full), 8'd1);
        chk("seq_ready_3", 8'(card_ready), 8'd0);
        deal(4'd5);
        chk("ign_total", 8'(total), 8'd4);
        chk("ign_count", 8'(count), 8'd3);

        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_count", 8'(count), 8'd0);
        chk("clr_total", 8'(total), 8'd0);
        chk("clr_ready", 8'(card_ready), 8'd1);

        // Face and out-of-range codes score zero but still count.
        deal(4'd10);
        chk("face_t_total", 8'(total), 8'd0);
        chk("face_t_count", 8'(count), 8'd1);
        deal(4'd13);
        chk("face_k_total", 8'(total), 8'd0);
        deal(4'd15);
        chk("face_15_total", 8'(total), 8'd0);
        chk("face_15_count", 8'(count), 8'd3);
        chk("face_15_full", 8'(full), 8'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        deal(4'd0);
        chk("zero_count", 8'(count), 8'd1);
        chk("zero_total", 8'(total), 8'd0);

        // Clear wins over a card presented on the same edge.
        clear = 1'b1; tick(); clear = 1'b0;
        deal(4'd3);
        deal(4'd4);
        chk("coll_pre_total", 8'(total), 8'd7);
        clear = 1'b1; card_valid = 1'b1; card = 4'd6;
        tick();
        clear = 1'b0; card_valid = 1'b0;
        chk("coll_total", 8'(total), 8'd0);
        chk("coll_count", 8'(count), 8'd0);

        deal(4'd4);
        deal(4'd5);
        chk("nat_total", 8'(total), 8'd9);
        chk("nat_count", 8'(count), 8'd2);
`ifdef HAND_NATURAL_EN
        chk("nat_flag", 8'(natural), 8'd1);
        chk("nat_ready", 8'(card_ready), 8'd0);
        deal(4'd2);
        chk("nat_hold_total", 8'(total), 8'd9);
        chk("nat_hold_count", 8'(count), 8'd2);
`else
        chk("nat_flag", 8'(natural), 8'd0);
        chk("nat_ready", 8'(card_ready), 8'd1);
        deal(4'd2);
        chk("nat_next_total", 8'(total), 8'd1);
        chk("nat_next_count", 8'(count), 8'd3);
`endif

        // Reset mid-hand discards the partial score.
        clear = 1'b1; tick(); clear = 1'b0;
        deal(4'd6);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_total", 8'(total), 8'd0);
        chk("midrst_count", 8'(count), 8'd0);

        // Sweep instance: modulus 12, five cards of value 9.
        deal1(4'd9);
        chk("sw_total_1", 8'(total1), 8'd9);
        deal1(4'd9);
        chk("sw_total_2", 8'(total1), 8'd6);
        chk("sw_natural_2", 8'(natural1), 8'd0);
        deal1(4'd9);
        chk("sw_total_3", 8'(total1), 8'd3);
        deal1(4'd9);
        chk("sw_total_4", 8'(total1), 8'd0);
        chk("sw_full_4", 8'(full1), 8'd0);
        chk("sw_ready_4", 8'(card_ready1), 8'd1);
        deal1(4'd9);
        chk("sw_total_5", 8'(total1), 8'd9);
        chk("sw_count_5", 8'(count1), 8'd5);
        chk("sw_full_5", 8'(full1), 8'd1);
        chk("sw_ready_5", 8'(card_ready1), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
